// File: rtl/datapath_seq_if.sv
// -----------------------------------------------------------------------------
// datapath_seq_if
//   Instruction handshake channel into the datapath sequencer.
//
//   in_valid  producer -> consumer  instruction offered
//   in_ready  consumer -> producer  consumer can accept (FIFO not full)
//   in_op     producer -> consumer  3-bit ALU control code
//   in_rd     producer -> consumer  destination register index
//   in_rs1    producer -> consumer  first source register index
//   in_rs2    producer -> consumer  second source register index
//
//   Modports: master = instruction producer, slave = sequencer.
// -----------------------------------------------------------------------------
interface datapath_seq_if;
    logic       in_valid;
    logic       in_ready;
    logic [2:0] in_op;
    logic [1:0] in_rd;
    logic [1:0] in_rs1;
    logic [1:0] in_rs2;

    modport master (
        output in_valid, in_op, in_rd, in_rs1, in_rs2,
        input  in_ready
    );

    modport slave (
        input  in_valid, in_op, in_rd, in_rs1, in_rs2,
        output in_ready
    );
endinterface

// File: rtl/datapath_seq.sv
// -----------------------------------------------------------------------------
// datapath_seq
//   Instruction sequencer for the 4-register, 32-bit datapath. Instructions
//   arrive on a valid/ready channel, are buffered in a FIFO, and are issued as
//   a two-cycle EXEC/WB sequence on the datapath address/control ports. Each
//   retired instruction is reported with a one-cycle res_valid pulse.
//
//   Parameters
//     FIFO_DEPTH      instruction buffer entries (power of two, >= 2)
//
//   Ports
//     clk             rising-edge clock
//     rst             synchronous, active-high reset
//     in_if           instruction channel (slave side)
//     dp_addr1/2      source register addresses (rs1, rs2)
//     dp_addr3        destination register address (rd)
//     dp_alu_control  ALU control code (op)
//     dp_wr           register-file write strobe, high only in WB
//     dp_result       ALU result from the datapath
//     res_valid       one-cycle pulse per retired instruction
//     res_data        result captured at retire, held until next retire
//     res_rd          destination of the retired instruction
//     r0_blocked      pulses with res_valid when a write to R0 was suppressed
//     busy            FSM not idle or FIFO non-empty
//     count           FIFO occupancy
//
//   Configuration
//     DATAPATH_SEQ_R0_PROTECT_EN  when defined, writes to R0 are suppressed
//                                 and flagged on r0_blocked; otherwise R0 is
//                                 an ordinary register and r0_blocked is 0.
// -----------------------------------------------------------------------------
module datapath_seq #(
    parameter int FIFO_DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    datapath_seq_if.slave                 in_if,
    output logic [1:0]                    dp_addr1,
    output logic [1:0]                    dp_addr2,
    output logic [1:0]                    dp_addr3,
    output logic [2:0]                    dp_alu_control,
    output logic                          dp_wr,
    input  logic [31:0]                   dp_result,
    output logic                          res_valid,
    output logic [31:0]                   res_data,
    output logic [1:0]                    res_rd,
    output logic                          r0_blocked,
    output logic                          busy,
    output logic [$clog2(FIFO_DEPTH):0]   count
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef enum logic [1:0] {IDLE, EXEC, WB} state_t;

    typedef struct packed {
        logic [2:0] op;
        logic [1:0] rd;
        logic [1:0] rs1;
        logic [1:0] rs2;
    } instr_t;

    state_t             state_q, state_d;
    instr_t             instr_q, instr_d;
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic               res_valid_q, res_valid_d;
    logic [31:0]        res_data_q, res_data_d;
    logic [1:0]         res_rd_q, res_rd_d;
    logic               r0_blocked_q, r0_blocked_d;

    instr_t             fifo_mem [FIFO_DEPTH];
    instr_t             in_entry;
    logic               full, empty, push, pop;

    assign full     = (count_q == CNT_W'(FIFO_DEPTH));
    assign empty    = (count_q == '0);
    // Acceptance uses the pre-edge full flag, so a pop on the same edge does
    // not let a push into a full FIFO.
    assign push     = in_if.in_valid && !full;
    assign in_entry = '{op: in_if.in_op, rd: in_if.in_rd,
                        rs1: in_if.in_rs1, rs2: in_if.in_rs2};

    // NOTE: every signal assigned here gets a default first; a path that
    // leaves one unassigned would infer a latch.
    always_comb begin
        state_d        = state_q;
        instr_d        = instr_q;
        pop            = 1'b0;
        res_valid_d    = 1'b0;
        res_data_d     = res_data_q;
        res_rd_d       = res_rd_q;
        r0_blocked_d   = 1'b0;
        dp_addr1       = '0;
        dp_addr2       = '0;
        dp_addr3       = '0;
        dp_alu_control = '0;
        dp_wr          = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (!empty) begin
                    pop     = 1'b1;
                    instr_d = fifo_mem[rd_ptr_q];
                    state_d = EXEC;
                end
            end
            EXEC: begin
                dp_addr1       = instr_q.rs1;
                dp_addr2       = instr_q.rs2;
                dp_addr3       = instr_q.rd;
                dp_alu_control = instr_q.op;
                state_d        = WB;
            end
            WB: begin
                dp_addr1       = instr_q.rs1;
                dp_addr2       = instr_q.rs2;
                dp_addr3       = instr_q.rd;
                dp_alu_control = instr_q.op;
`ifdef DATAPATH_SEQ_R0_PROTECT_EN
                dp_wr          = (instr_q.rd != 2'd0);
                r0_blocked_d   = (instr_q.rd == 2'd0);
`else
                dp_wr          = 1'b1;
`endif
                res_valid_d    = 1'b1;
                res_data_d     = dp_result;
                res_rd_d       = instr_q.rd;
                // Chain straight into the next instruction with no IDLE bubble.
                if (!empty) begin
                    pop     = 1'b1;
                    instr_d = fifo_mem[rd_ptr_q];
                    state_d = EXEC;
                end else begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        wr_ptr_d = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
        count_d  = count_q + CNT_W'(push) - CNT_W'(pop);
    end

    // NOTE: state registers use non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            instr_q      <= '0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            res_valid_q  <= 1'b0;
            res_data_q   <= '0;
            res_rd_q     <= '0;
            r0_blocked_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            instr_q      <= instr_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            res_valid_q  <= res_valid_d;
            res_data_q   <= res_data_d;
            res_rd_q     <= res_rd_d;
            r0_blocked_q <= r0_blocked_d;
        end
    end

    // NOTE: the storage array is not reset; entries are only read when count
    // says they were written, so reset clears the pointers and count instead.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr_q] <= in_entry;
        end
    end

    assign in_if.in_ready = !full;
    assign res_valid      = res_valid_q;
    assign res_data       = res_data_q;
    assign res_rd         = res_rd_q;
    assign r0_blocked     = r0_blocked_q;
    assign busy           = (state_q != IDLE) || !empty;
    assign count          = count_q;
endmodule

// File: tb/tb_datapath_seq.sv
// -----------------------------------------------------------------------------
// tb_datapath_seq
//   Directed bench for datapath_seq (FIFO_DEPTH = 4). A stand-in datapath
//   returns a result that encodes the addresses/op it was driven with, so a
//   retired result identifies which instruction actually executed.
// -----------------------------------------------------------------------------
module tb_datapath_seq;
`ifdef DATAPATH_SEQ_R0_PROTECT_EN
    localparam bit PROTECT = 1'b1;
`else
    localparam bit PROTECT = 1'b0;
`endif

    logic        clk;
    logic        rst;
    logic [1:0]  dp_addr1, dp_addr2, dp_addr3;
    logic [2:0]  dp_alu_control;
    logic        dp_wr;
    logic [31:0] dp_result;
    logic        res_valid;
    logic [31:0] res_data;
    logic [1:0]  res_rd;
    logic        r0_blocked;
    logic        busy;
    logic [2:0]  count;

    datapath_seq_if in_if ();

    datapath_seq #(.FIFO_DEPTH(4)) dut (
        .clk            (clk),
        .rst            (rst),
        .in_if          (in_if),
        .dp_addr1       (dp_addr1),
        .dp_addr2       (dp_addr2),
        .dp_addr3       (dp_addr3),
        .dp_alu_control (dp_alu_control),
        .dp_wr          (dp_wr),
        .dp_result      (dp_result),
        .res_valid      (res_valid),
        .res_data       (res_data),
        .res_rd         (res_rd),
        .r0_blocked     (r0_blocked),
        .busy           (busy),
        .count          (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Entry packing: {op[2:0], rd[1:0], rs1[1:0], rs2[1:0]}.
    function automatic logic [31:0] fake_alu(input logic [8:0] e);
        return {16'hC0DE, 5'd0, e[8:6], 2'b00, e[5:4], e[3:2], e[1:0]};
    endfunction

    assign dp_result = fake_alu({dp_alu_control, dp_addr3, dp_addr1, dp_addr2});

    int         checks = 0;
    int         errors = 0;
    int         cyc    = 0;
    int         n_ret  = 0;
    logic       prev_wr = 1'b0;
    logic [8:0] exp_q [$];
    int         wr_cyc [$];

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance one edge and sample 1 time unit later; track dp_wr pulses and
    // score every retire against the expected-order queue.
    task automatic tick_mon();
        logic [8:0] e;
        @(posedge clk);
        #1;
        cyc++;
        if (dp_wr) begin
            wr_cyc.push_back(cyc);
            if (prev_wr) check("wr_consecutive", 32'd1, 32'd0);
        end
        prev_wr = dp_wr;
        if (res_valid) begin
            n_ret++;
            if (exp_q.size() == 0) begin
                check("spurious_retire", 32'd1, 32'd0);
            end else begin
                e = exp_q.pop_front();
                check("ret_rd", 32'(res_rd), 32'(e[5:4]));
                check("ret_data", res_data, fake_alu(e));
                check("ret_r0_blocked", 32'(r0_blocked),
                      32'(PROTECT && (e[5:4] == 2'd0)));
            end
        end else begin
            check("r0_blocked_idle", 32'(r0_blocked), 32'd0);
        end
    endtask

    // Offer one instruction for one edge; it is expected to retire only if
    // in_ready was high before that edge.
    task automatic push(input logic [8:0] e);
        in_if.in_valid = 1'b1;
        {in_if.in_op, in_if.in_rd, in_if.in_rs1, in_if.in_rs2} = e;
        if (in_if.in_ready) exp_q.push_back(e);
        tick_mon();
    endtask

    initial begin
        logic [8:0] e;

        // ---------------- reset ----------------
        rst = 1'b1;
        in_if.in_valid = 1'b0;
        {in_if.in_op, in_if.in_rd, in_if.in_rs1, in_if.in_rs2} = '0;
        tick_mon();
        tick_mon();
        check("rst_in_ready", 32'(in_if.in_ready), 32'd1);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_count", 32'(count), 32'd0);
        check("rst_dp_wr", 32'(dp_wr), 32'd0);
        check("rst_dp_addr", 32'({dp_addr1, dp_addr2, dp_addr3}), 32'd0);
        check("rst_dp_alu", 32'(dp_alu_control), 32'd0);
        check("rst_res_valid", 32'(res_valid), 32'd0);
        check("rst_res_data", res_data, 32'd0);
        check("rst_res_rd", 32'(res_rd), 32'd0);
        rst = 1'b0;

        // ---------------- single subtract: op=1 rd=2 rs1=0 rs2=2 ----------------
        push({3'b001, 2'd2, 2'd0, 2'd2});           // E0
        in_if.in_valid = 1'b0;
        check("e0_count", 32'(count), 32'd1);
        check("e0_busy", 32'(busy), 32'd1);
        check("e0_dp_wr", 32'(dp_wr), 32'd0);
        tick_mon();                                 // E1: EXEC
        check("exec_addr1", 32'(dp_addr1), 32'd0);
        check("exec_addr2", 32'(dp_addr2), 32'd2);
        check("exec_addr3", 32'(dp_addr3), 32'd2);
        check("exec_alu", 32'(dp_alu_control), 32'd1);
        check("exec_dp_wr", 32'(dp_wr), 32'd0);
        check("exec_count", 32'(count), 32'd0);
        tick_mon();                                 // E2: WB
        check("wb_dp_wr", 32'(dp_wr), 32'd1);
        check("wb_res_valid", 32'(res_valid), 32'd0);
        tick_mon();                                 // E3: retire
        check("ret_valid", 32'(res_valid), 32'd1);
        check("ret_rd_sub", 32'(res_rd), 32'd2);
        check("ret_data_sub", res_data, 32'hC0DE_0122);
        check("ret_dp_wr", 32'(dp_wr), 32'd0);
        check("ret_busy", 32'(busy), 32'd0);
        tick_mon();
        check("hold_valid", 32'(res_valid), 32'd0);
        check("hold_data", res_data, 32'hC0DE_0122);

        // ---------------- back-to-back ----------------
        wr_cyc.delete();
        n_ret = 0;
        push({3'b010, 2'd1, 2'd2, 2'd3});
        push({3'b011, 2'd3, 2'd1, 2'd0});
        push({3'b100, 2'd2, 2'd3, 2'd1});
        in_if.in_valid = 1'b0;
        repeat (10) tick_mon();
        check("b2b_retires", 32'(n_ret), 32'd3);
        check("b2b_wr_pulses", 32'(wr_cyc.size()), 32'd3);
        if (wr_cyc.size() == 3) begin
            check("b2b_gap01", 32'(wr_cyc[1] - wr_cyc[0]), 32'd2);
            check("b2b_gap12", 32'(wr_cyc[2] - wr_cyc[1]), 32'd2);
        end
        check("b2b_drained", 32'(exp_q.size()), 32'd0);
        check("b2b_busy", 32'(busy), 32'd0);

        // ---------------- full FIFO: valid held for 8 edges ----------------
        n_ret = 0;
        for (int i = 0; i < 8; i++) begin
            if (i == 7) begin
                check("full_count", 32'(count), 32'd4);
                check("full_ready", 32'(in_if.in_ready), 32'd0);
            end
            e = {3'(i), 2'(i), 2'(i + 1), 2'(i + 2)};
            push(e);
        end
        in_if.in_valid = 1'b0;
        check("after_pop_count", 32'(count), 32'd3);
        check("after_pop_ready", 32'(in_if.in_ready), 32'd1);
        repeat (20) tick_mon();
        check("full_retires", 32'(n_ret), 32'd7);
        check("full_drained", 32'(exp_q.size()), 32'd0);

        // ---------------- reset in WB with 2 entries queued ----------------
        push({3'b001, 2'd1, 2'd0, 2'd1});
        push({3'b010, 2'd2, 2'd1, 2'd2});
        push({3'b011, 2'd3, 2'd2, 2'd3});
        in_if.in_valid = 1'b0;
        check("mid_wb_dp_wr", 32'(dp_wr), 32'd1);
        check("mid_wb_count", 32'(count), 32'd2);
        rst = 1'b1;
        exp_q.delete();
        tick_mon();
        rst = 1'b0;
        check("rstwb_dp_wr", 32'(dp_wr), 32'd0);
        check("rstwb_count", 32'(count), 32'd0);
        check("rstwb_res_valid", 32'(res_valid), 32'd0);
        check("rstwb_busy", 32'(busy), 32'd0);
        wr_cyc.delete();
        n_ret = 0;
        repeat (8) tick_mon();
        check("rstwb_no_retire", 32'(n_ret), 32'd0);
        check("rstwb_no_wr", 32'(wr_cyc.size()), 32'd0);

        // ---------------- write to R0 ----------------
        wr_cyc.delete();
        n_ret = 0;
        push({3'b000, 2'd0, 2'd1, 2'd2});
        in_if.in_valid = 1'b0;
        repeat (5) tick_mon();
        check("r0_retires", 32'(n_ret), 32'd1);
        check("r0_wr_pulses", 32'(wr_cyc.size()), PROTECT ? 32'd0 : 32'd1);
        check("r0_res_rd", 32'(res_rd), 32'd0);
        check("r0_res_data", res_data, 32'hC0DE_0006);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
